pll_lock_supervisor: RTL and testbench

Supervises the on-chip rPLL from the reference-clock side.
- Drives the PLL RESET input and watches its LOCK output.
- Qualifies lock as stable before releasing the system reset.
- Re-arms the PLL on timeout or loss of lock, up to a retry limit, then latches a fault.
- Sits between the PLL wrapper and the top-level reset tree of the NPU fabric.

---
 rtl/pll_lock_supervisor.sv | 134 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies LOCK as stable and releases the system reset.
// Optional macro PLL_LOCK_SUP_GLITCH_FILTER_EN makes RUN tolerate lock dips shorter than GLITCH_CYCLES.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7,
    parameter int GLITCH_CYCLES       = 4
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       pll_lock_i,
    input  logic       clear_fault_i,
    output logic       pll_reset_o,
    output logic       sys_rst_n_o,
    output logic       locked_o,
    output logic       fault_o,
    output logic [3:0] retry_cnt_o
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CD  = (LOCK_STABLE_CYCLES > GLITCH_CYCLES) ? LOCK_STABLE_CYCLES : GLITCH_CYCLES;
    localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);
`ifdef PLL_LOCK_SUP_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] GLITCH_LAST  = CNT_W'(GLITCH_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             sync_q, lock_s_q;
    logic             pll_reset_q, sys_rst_n_q, locked_q, fault_q;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle still wins over the retry.
                if (lock_s_q) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = RESET_PLL;
                    end
                end
            end
            STABLE: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
`ifdef PLL_LOCK_SUP_GLITCH_FILTER_EN
                // The shared counter doubles as the lock-low persistence filter.
                if (lock_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == GLITCH_LAST) begin
                    state_d = RESET_PLL;
                end
`else
                cnt_d = '0;
                if (!lock_s_q) state_d = RESET_PLL;
`endif
            end
            FAULT: begin
                cnt_d = '0;
                if (clear_fault_i) begin
                    state_d = RESET_PLL;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            sync_q      <= pll_lock_i;
            lock_s_q    <= sync_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= (state_d == RESET_PLL) || (state_d == FAULT);
            sys_rst_n_q <= (state_d == RUN);
            locked_q    <= (state_d == RUN);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign pll_reset_o = pll_reset_q;
    assign sys_rst_n_o = sys_rst_n_q;
    assign locked_o    = locked_q;
    assign fault_o     = fault_q;
    assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed-random bench for pll_lock_supervisor; expectations are edge counts derived from the lock/retry rules.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

    localparam int P   = 4;
    localparam int TO  = 32;
    localparam int LSC = 8;
    localparam int MR  = 2;
    localparam int G   = 3;

    // Edge counts are inclusive of the edge that first samples the new pll_lock_i value.
    localparam int REL_EDGES = 3 + LSC;
`ifdef PLL_LOCK_SUP_GLITCH_FILTER_EN
    localparam int LOSS_EDGES = 2 + G;
`else
    localparam int LOSS_EDGES = 3;
`endif

    logic       clkin = 1'b0;
    logic       rst_n;
    logic       pll_lock_i;
    logic       clear_fault_i;
    logic       pll_reset_o;
    logic       sys_rst_n_o;
    logic       locked_o;
    logic       fault_o;
    logic [3:0] retry_cnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clkin = ~clkin;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (P),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (LSC),
        .MAX_RETRIES         (MR),
        .GLITCH_CYCLES       (G)
    ) dut (
        .clkin         (clkin),
        .rst_n         (rst_n),
        .pll_lock_i    (pll_lock_i),
        .clear_fault_i (clear_fault_i),
        .pll_reset_o   (pll_reset_o),
        .sys_rst_n_o   (sys_rst_n_o),
        .locked_o      (locked_o),
        .fault_o       (fault_o),
        .retry_cnt_o   (retry_cnt_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic lock, input logic clr);
        pll_lock_i    = lock;
        clear_fault_i = clr;
        @(negedge clkin);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clkin);
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return pll_reset_o;
            1:       return sys_rst_n_o;
            2:       return locked_o;
            default: return fault_o;
        endcase
    endfunction

    // Returns the number of edges until the selected output reaches val, or -1 if the bound expires.
    task automatic waitUntil(input int sel, input logic val, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clkin);
            if (pick(sel) === val) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s, j, n, highs;
        int lows;
        rst_n         = 1'b0;
        pll_lock_i    = 1'b0;
        clear_fault_i = 1'b0;
        step(3);

        $display("[TB] reset values");
        checkOutput("rst_pll_reset", pll_reset_o, 1);
        checkOutput("rst_sys_rst_n", sys_rst_n_o, 0);
        checkOutput("rst_locked", locked_o, 0);
        checkOutput("rst_fault", fault_o, 0);
        checkOutput("rst_retry", retry_cnt_o, 0);

        $display("[TB] normal start");
        rst_n = 1'b1;
        waitUntil(0, 1'b0, P + 10, n);
        checkOutput("start_pll_reset_width", n, P);
        s = $urandom_range(0, TO - 3);
        step(s);
        pll_lock_i = 1'b1;
        waitUntil(1, 1'b1, REL_EDGES + 10, n);
        checkOutput("start_release_lat", n, REL_EDGES);
        checkOutput("start_locked", locked_o, 1);
        checkOutput("start_retry", retry_cnt_o, 0);

        $display("[TB] clear_fault_i in RUN");
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        step(3);
        checkOutput("run_clear_locked", locked_o, 1);
        checkOutput("run_clear_sys_rst_n", sys_rst_n_o, 1);
        checkOutput("run_clear_fault", fault_o, 0);

        $display("[TB] lock loss in RUN");
`ifdef PLL_LOCK_SUP_GLITCH_FILTER_EN
        pll_lock_i = 1'b0;
        step(G - 1);
        pll_lock_i = 1'b1;
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clkin);
            if (!sys_rst_n_o) lows++;
        end
        checkOutput("run_short_dip_ignored", lows, 0);
`endif
        pll_lock_i = 1'b0;
        waitUntil(1, 1'b0, LOSS_EDGES + 10, n);
        checkOutput("loss_lat", n, LOSS_EDGES);
        checkOutput("loss_locked", locked_o, 0);
        checkOutput("loss_pll_reset", pll_reset_o, 1);
        waitUntil(0, 1'b0, P + 10, n);
        checkOutput("loss_pll_reset_width", n, P);

        $display("[TB] lock glitch in STABLE");
        s = $urandom_range(0, TO - 3);
        step(s);
        j = $urandom_range(1, LSC);
        pll_lock_i = 1'b1;
        highs = 0;
        repeat (j) begin
            @(negedge clkin);
            if (sys_rst_n_o) highs++;
        end
        pll_lock_i = 1'b0;
        @(negedge clkin);
        if (sys_rst_n_o) highs++;
        pll_lock_i = 1'b1;
        waitUntil(1, 1'b1, REL_EDGES + 10, n);
        checkOutput("glitch_no_early_release", highs, 0);
        checkOutput("glitch_release_lat", n, REL_EDGES);
        checkOutput("glitch_retry", retry_cnt_o, 0);

        $display("[TB] timeouts and retries");
        pll_lock_i = 1'b0;
        waitUntil(1, 1'b0, LOSS_EDGES + 10, n);
        checkOutput("loss2_lat", n, LOSS_EDGES);
        for (int a = 0; a <= MR; a++) begin
            waitUntil(0, 1'b0, P + 10, n);
            checkOutput("retry_pll_reset_width", n, P);
            waitUntil(0, 1'b1, TO + 10, n);
            checkOutput("retry_timeout_len", n, TO);
            if (a < MR) begin
                checkOutput("retry_cnt", retry_cnt_o, a + 1);
                checkOutput("retry_no_fault", fault_o, 0);
            end else begin
                checkOutput("fault_set", fault_o, 1);
                checkOutput("fault_sys_rst_n", sys_rst_n_o, 0);
                checkOutput("fault_retry", retry_cnt_o, MR);
            end
        end

        $display("[TB] fault hold and clear");
        s = $urandom_range(2, 10);
        step(s);
        checkOutput("fault_holds", fault_o, 1);
        checkOutput("fault_pll_reset", pll_reset_o, 1);
        applyStimulus(1'b0, 1'b1);
        clear_fault_i = 1'b0;
        checkOutput("clear_fault_low", fault_o, 0);
        checkOutput("clear_retry", retry_cnt_o, 0);
        checkOutput("clear_pll_reset", pll_reset_o, 1);
        waitUntil(0, 1'b0, P + 10, n);
        checkOutput("clear_pll_reset_width", n, P);
        // Lock is timed to land on the timeout cycle itself.
        step(TO - 3);
        pll_lock_i = 1'b1;
        waitUntil(1, 1'b1, REL_EDGES + 10, n);
        checkOutput("lock_on_timeout_edge_lat", n, REL_EDGES);
        checkOutput("relock_retry", retry_cnt_o, 0);
        checkOutput("relock_fault", fault_o, 0);

        $display("[TB] async reset mid-STABLE");
        pll_lock_i = 1'b0;
        waitUntil(1, 1'b0, LOSS_EDGES + 10, n);
        checkOutput("loss3_lat", n, LOSS_EDGES);
        waitUntil(0, 1'b0, P + 10, n);
        checkOutput("loss3_pll_reset_width", n, P);
        waitUntil(0, 1'b1, TO + 10, n);
        checkOutput("loss3_timeout_len", n, TO);
        checkOutput("loss3_retry", retry_cnt_o, 1);
        waitUntil(0, 1'b0, P + 10, n);
        checkOutput("loss3_pll_reset_width2", n, P);
        pll_lock_i = 1'b1;
        step(5);
        checkOutput("stable_pll_reset", pll_reset_o, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_pll_reset", pll_reset_o, 1);
        checkOutput("async_sys_rst_n", sys_rst_n_o, 0);
        checkOutput("async_locked", locked_o, 0);
        checkOutput("async_fault", fault_o, 0);
        checkOutput("async_retry", retry_cnt_o, 0);
        pll_lock_i = 1'b0;
        @(negedge clkin);
        rst_n = 1'b1;
        waitUntil(0, 1'b0, P + 10, n);
        checkOutput("restart_pll_reset_width", n, P);
        s = $urandom_range(0, TO - 3);
        step(s);
        pll_lock_i = 1'b1;
        waitUntil(1, 1'b1, REL_EDGES + 10, n);
        checkOutput("restart_release_lat", n, REL_EDGES);
        checkOutput("restart_retry", retry_cnt_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
